ps2_scan_rx: RTL and testbench
==============================

Name: ps2_scan_rx

Overview:
Parametrised PS/2 keyboard receiver that decodes full 11-bit device-to-host frames:
- start, 8 data bits LSB-first, odd parity, stop.
- Handles 0xE0 extended and 0xF0 break prefixes.
- Keeps a DEPTH-entry scancode history for the hex display path.

It sits between the keyboard pins and the display and control logic. Compared with the earlier receiver it adds parity and stop checking, a frame timeout, prefix tracking and a configurable history depth.

Parameters:
DEPTH, 2, number of history slots (1..8); slot 0 is the newest.
DEB_CYCLES, 4, consecutive equal samples required before filtered kbclk changes (2..255).
TIMEOUT_CYCLES, 50000, clk cycles without a kbclk falling edge before an open frame is abandoned.
STORE_BREAK, 0, 1: break codes also enter history; 0: only make codes enter history.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
kbclk  input  1  raw PS/2 clock pin, asynchronous
in  input  1  raw PS/2 data pin, asynchronous
clear  input  1  synchronous history/count clear, one-cycle pulse
code_valid  output  1  one-cycle pulse: completed scancode on code
code  output  8  last completed scancode (prefixes stripped)
is_break  output  1  code was preceded by 0xF0
is_ext  output  1  code was preceded by 0xE0
frame_err  output  1  one-cycle pulse: parity, stop or timeout failure
history  output  8*DEPTH  slot k at bits [8k+7:8k]
hist_count  output  4  valid slots, saturates at DEPTH

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FSM to IDLE; prefix flags, bit counter, timeout counter and filter state cleared; filtered kbclk = 1.
- Input path:
  - kbclk and in each pass through a 2-FF synchroniser.
  - Filtered kbclk takes the synchronised value only after DEB_CYCLES consecutive equal samples.
  - A sample event is the cycle in which the registered filtered kbclk goes 1->0. Synchronised in is sampled in that same cycle.
- FSM, advancing only on sample events:
  - IDLE: in=0 -> DATA with bitcnt=0. in=1 -> stay in IDLE; this is a glitch, not an error.
  - DATA: shift[bitcnt]=in; bitcnt+1; after bit 7 -> PARITY.
  - PARITY: store in as the parity bit -> STOP.
  - STOP: go to IDLE. The frame is good iff in=1 and XOR(shift, parity)=1 (odd parity). Otherwise pulse frame_err; prefix flags are kept.
- Timeout:
  - In any non-IDLE state, a counter reloads on each sample event.
  - Reaching TIMEOUT_CYCLES -> IDLE and a frame_err pulse in the same cycle; the partial byte is discarded.
  - A reset mid-frame discards the frame with no pulse.
- Good-byte decode, in the cycle after the STOP event:
  - 0xE0: set ext flag, no output.
  - 0xF0: set brk flag, no output.
  - Any other byte:
    - code=byte, is_break=brk, is_ext=ext; code_valid=1 for one cycle.
    - Both flags cleared.
    - code, is_break and is_ext hold until the next code.
- Latency: code_valid is asserted exactly 1 clk after the sample event of the stop bit.
- History:
  - On code_valid, when (is_break==0 or STORE_BREAK==1): slot k <= slot k-1 for k=DEPTH-1..1, slot 0 <= code; hist_count increments, saturating at DEPTH.
  - The oldest entry is dropped when full.
- clear:
  - Zeroes history and hist_count next cycle.
  - If it coincides with a history write, clear wins; code_valid still pulses.
  - Does not affect the FSM or prefix flags.
- Width rules:
  - bitcnt is 3 bits.
  - The timeout counter is sized with $clog2(TIMEOUT_CYCLES+1).
  - hist_count is 4 bits and is compared against DEPTH.

Test Plan:
- Frame 0x1C (bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at 10 kHz kbclk -> code_valid once, code=0x1C, is_break=0, is_ext=0, history[7:0]=0x1C, hist_count=1.
- Sequence F0,1C with STORE_BREAK=0 -> code_valid with code=0x1C, is_break=1; history unchanged. Repeat with STORE_BREAK=1 -> slot 0 becomes 0x1C.
- E0,F0,75 -> code=0x75, is_ext=1, is_break=1. A following 0x1C has both flags 0.
- 0x1C sent with parity bit 1 -> frame_err pulse, no code_valid. Next frame 0x32 (parity 0) decodes correctly.
- Start plus 4 data bits, then kbclk held high for TIMEOUT_CYCLES -> frame_err pulse, FSM in IDLE. Next full frame 0x1C decodes.
- DEPTH=2: send 0x1C, 0x32, 0x21 -> history={0x32,0x21} (slot1=0x32, slot0=0x21), hist_count=2. Then clear -> history=0, hist_count=0. A 1-cycle kbclk glitch shorter than DEB_CYCLES produces no sample event.

Source files
------------

// File: rtl/ps2_scan_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scan_rx
// Description : PS/2 device-to-host frame receiver with debounced clock,
//               parity/stop/timeout checking, E0/F0 prefix tracking and a
//               DEPTH-entry scancode history.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_scan_rx #(
    parameter int DEPTH          = 2,
    parameter int DEB_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int STORE_BREAK    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 kbclk,
    input  logic                 in,
    input  logic                 clear,
    output logic                 code_valid,
    output logic [7:0]           code,
    output logic                 is_break,
    output logic                 is_ext,
    output logic                 frame_err,
    output logic [8*DEPTH-1:0]   history,
    output logic [3:0]           hist_count
);

    localparam int C_TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    logic              r_kbclk_s1, r_kbclk_s2, r_in_s1, r_in_s2;
    logic [7:0]        r_deb_cnt;
    logic              r_kbclk_filt, r_kbclk_filt_d;
    state_t            r_state, w_state_next;
    logic [2:0]        r_bitcnt;
    logic [7:0]        r_shift;
    logic              r_parity;
    logic [C_TO_W-1:0] r_to_cnt;
    logic              r_ext, r_brk;
    logic              r_code_valid, r_is_break, r_is_ext, r_frame_err;
    logic [7:0]        r_code;
    logic [7:0]        r_hist [DEPTH];
    logic [3:0]        r_hist_cnt;
    logic              w_fall, w_to_hit, w_stop_evt, w_frame_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kbclk_s1     <= 1'b1;
            r_kbclk_s2     <= 1'b1;
            r_in_s1        <= 1'b1;
            r_in_s2        <= 1'b1;
            r_deb_cnt      <= 8'd0;
            r_kbclk_filt   <= 1'b1;
            r_kbclk_filt_d <= 1'b1;
        end else begin
            r_kbclk_s1     <= kbclk;
            r_kbclk_s2     <= r_kbclk_s1;
            r_in_s1        <= in;
            r_in_s2        <= r_in_s1;
            r_kbclk_filt_d <= r_kbclk_filt;
            // Filtered clock only follows after DEB_CYCLES disagreeing samples in a row
            if (r_kbclk_s2 == r_kbclk_filt) begin
                r_deb_cnt <= 8'd0;
            end else if (r_deb_cnt == 8'(DEB_CYCLES - 1)) begin
                r_kbclk_filt <= r_kbclk_s2;
                r_deb_cnt    <= 8'd0;
            end else begin
                r_deb_cnt <= r_deb_cnt + 8'd1;
            end
        end
    end

    assign w_fall     = r_kbclk_filt_d & ~r_kbclk_filt;
    assign w_to_hit   = (r_state != ST_IDLE) && !w_fall &&
                        (r_to_cnt == C_TO_W'(TIMEOUT_CYCLES - 1));
    assign w_frame_ok = r_in_s2 & (^r_shift ^ r_parity);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_stop_evt   = 1'b0;
        if (w_to_hit) begin
            w_state_next = ST_IDLE;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE:   if (!r_in_s2) w_state_next = ST_DATA;
                ST_DATA:   if (r_bitcnt == 3'd7) w_state_next = ST_PARITY;
                ST_PARITY: w_state_next = ST_STOP;
                ST_STOP: begin
                    w_state_next = ST_IDLE;
                    w_stop_evt   = 1'b1;
                end
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitcnt <= 3'd0;
            r_shift  <= 8'd0;
            r_parity <= 1'b0;
            r_to_cnt <= '0;
        end else begin
            if (r_state == ST_IDLE || w_fall || w_to_hit) r_to_cnt <= '0;
            else                                          r_to_cnt <= r_to_cnt + 1'b1;
            if (w_fall) begin
                case (r_state)
                    ST_IDLE: r_bitcnt <= 3'd0;
                    ST_DATA: begin
                        r_shift[r_bitcnt] <= r_in_s2;
                        r_bitcnt          <= r_bitcnt + 3'd1;
                    end
                    ST_PARITY: r_parity <= r_in_s2;
                    default: ;
                endcase
            end
        end
    end

    // Prefix bytes only arm flags; a failed frame leaves the flags untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            r_code_valid <= 1'b0;
            r_code       <= 8'd0;
            r_is_break   <= 1'b0;
            r_is_ext     <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_code_valid <= 1'b0;
            r_frame_err  <= w_to_hit;
            if (w_stop_evt) begin
                if (!w_frame_ok) begin
                    r_frame_err <= 1'b1;
                end else if (r_shift == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_brk <= 1'b1;
                end else begin
                    r_code       <= r_shift;
                    r_is_break   <= r_brk;
                    r_is_ext     <= r_ext;
                    r_code_valid <= 1'b1;
                    r_ext        <= 1'b0;
                    r_brk        <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) r_hist[k] <= 8'd0;
            r_hist_cnt <= 4'd0;
        end else if (clear) begin
            for (int k = 0; k < DEPTH; k++) r_hist[k] <= 8'd0;
            r_hist_cnt <= 4'd0;
        end else if (r_code_valid && (!r_is_break || STORE_BREAK != 0)) begin
            for (int k = DEPTH - 1; k > 0; k--) r_hist[k] <= r_hist[k-1];
            r_hist[0] <= r_code;
            if (r_hist_cnt < 4'(DEPTH)) r_hist_cnt <= r_hist_cnt + 4'd1;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_hist
        assign history[8*k +: 8] = r_hist[k];
    end

    assign code_valid = r_code_valid;
    assign code       = r_code;
    assign is_break   = r_is_break;
    assign is_ext     = r_is_ext;
    assign frame_err  = r_frame_err;
    assign hist_count = r_hist_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ps2_scan_rx
// Description : Directed frame table plus hand sequences for ps2_scan_rx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_scan_rx;

    localparam int DEPTH      = 2;
    localparam int DEB        = 4;
    localparam int TMO        = 300;
    localparam int HALF       = 50;   // 1 MHz clk -> 10 kHz kbclk
    localparam int GLITCH_LEN = DEB - 1;
    localparam int EXP_LAT    = 2 + DEB + 1;

    logic clk, rst_n, kbclk, kb_data, clear;
    logic code_valid, is_break, is_ext, frame_err;
    logic [7:0] code;
    logic [8*DEPTH-1:0] history, history_sb;
    logic [3:0] hist_count, hist_count_sb;
    logic cv_sb, brk_sb, ext_sb, err_sb;
    logic [7:0] code_sb;

    ps2_scan_rx #(.DEPTH(DEPTH), .DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .STORE_BREAK(0)) dut (
        .clk(clk), .rst_n(rst_n), .kbclk(kbclk), .in(kb_data), .clear(clear),
        .code_valid(code_valid), .code(code), .is_break(is_break), .is_ext(is_ext),
        .frame_err(frame_err), .history(history), .hist_count(hist_count));

    ps2_scan_rx #(.DEPTH(DEPTH), .DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .STORE_BREAK(1)) dut_sb (
        .clk(clk), .rst_n(rst_n), .kbclk(kbclk), .in(kb_data), .clear(clear),
        .code_valid(cv_sb), .code(code_sb), .is_break(brk_sb), .is_ext(ext_sb),
        .frame_err(err_sb), .history(history_sb), .hist_count(hist_count_sb));

    initial begin
        clk = 1'b0;
        forever #500 clk = ~clk;
    end

    int cyc = 0;
    int n_valid = 0;
    int n_err = 0;
    int total = 0;
    int bad = 0;
    int lat;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (code_valid) n_valid = n_valid + 1;
            if (frame_err)  n_err = n_err + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives nbits of an 11-bit frame; all input changes happen on negedge clk
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input bit glitch, input bit clr_on_valid, input int nbits);
        logic [10:0] f;
        int t0;
        f = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
        lat = -1;
        for (int i = 0; i < nbits; i++) begin
            kb_data = f[i];
            if (glitch) begin
                repeat (HALF / 2) @(negedge clk);
                kbclk = 1'b0;
                repeat (GLITCH_LEN) @(negedge clk);
                kbclk = 1'b1;
                repeat (HALF - HALF / 2 - GLITCH_LEN) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            kbclk = 1'b0;
            t0 = cyc;
            for (int j = 0; j < HALF; j++) begin
                @(negedge clk);
                if (code_valid && lat < 0) lat = cyc - t0;
                clear = clr_on_valid && code_valid;
            end
            kbclk = 1'b1;
        end
        clear = 1'b0;
        kb_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  data;
        bit          bad_par;
        bit          bad_stop;
        bit          glitch;
        int          exp_valid;
        int          exp_err;
        logic [7:0]  exp_code;
        bit          exp_brk;
        bit          exp_ext;
        logic [15:0] exp_hist;
        int          exp_cnt;
        logic [15:0] exp_hist_sb;
        int          exp_cnt_sb;
    } vec_t;

    vec_t vec [12];

    initial begin
        int v0, e0;
        vec[0]  = '{8'h1C, 0, 0, 0, 1, 0, 8'h1C, 0, 0, 16'h001C, 1, 16'h001C, 1};
        vec[1]  = '{8'hF0, 0, 0, 0, 0, 0, 8'h1C, 0, 0, 16'h001C, 1, 16'h001C, 1};
        vec[2]  = '{8'h1C, 0, 0, 0, 1, 0, 8'h1C, 1, 0, 16'h001C, 1, 16'h1C1C, 2};
        vec[3]  = '{8'hE0, 0, 0, 0, 0, 0, 8'h1C, 1, 0, 16'h001C, 1, 16'h1C1C, 2};
        vec[4]  = '{8'hF0, 0, 0, 0, 0, 0, 8'h1C, 1, 0, 16'h001C, 1, 16'h1C1C, 2};
        vec[5]  = '{8'h75, 0, 0, 0, 1, 0, 8'h75, 1, 1, 16'h001C, 1, 16'h1C75, 2};
        vec[6]  = '{8'h1C, 0, 0, 0, 1, 0, 8'h1C, 0, 0, 16'h1C1C, 2, 16'h751C, 2};
        vec[7]  = '{8'h1C, 1, 0, 0, 0, 1, 8'h1C, 0, 0, 16'h1C1C, 2, 16'h751C, 2};
        vec[8]  = '{8'h32, 0, 0, 0, 1, 0, 8'h32, 0, 0, 16'h1C32, 2, 16'h1C32, 2};
        vec[9]  = '{8'h21, 0, 0, 0, 1, 0, 8'h21, 0, 0, 16'h3221, 2, 16'h3221, 2};
        vec[10] = '{8'h55, 0, 1, 0, 0, 1, 8'h21, 0, 0, 16'h3221, 2, 16'h3221, 2};
        vec[11] = '{8'h6B, 0, 0, 1, 1, 0, 8'h6B, 0, 0, 16'h216B, 2, 16'h216B, 2};

        rst_n = 1'b0; kbclk = 1'b1; kb_data = 1'b1; clear = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("reset outputs", {8'h0, code_valid, code, is_break, is_ext, frame_err, history, hist_count}, 32'h0);
        check("reset sb history", {12'h0, history_sb, hist_count_sb}, 32'h0);

        foreach (vec[i]) begin
            v0 = n_valid; e0 = n_err;
            send_frame(vec[i].data, vec[i].bad_par, vec[i].bad_stop, vec[i].glitch, 1'b0, 11);
            check($sformatf("v%0d valid count", i), n_valid - v0, vec[i].exp_valid);
            check($sformatf("v%0d err count", i), n_err - e0, vec[i].exp_err);
            check($sformatf("v%0d code", i), {24'h0, code}, {24'h0, vec[i].exp_code});
            check($sformatf("v%0d flags", i), {30'h0, is_break, is_ext}, {30'h0, vec[i].exp_brk, vec[i].exp_ext});
            check($sformatf("v%0d history", i), {16'h0, history}, {16'h0, vec[i].exp_hist});
            check($sformatf("v%0d count", i), {28'h0, hist_count}, vec[i].exp_cnt);
            check($sformatf("v%0d sb history", i), {16'h0, history_sb}, {16'h0, vec[i].exp_hist_sb});
            check($sformatf("v%0d sb count", i), {28'h0, hist_count_sb}, vec[i].exp_cnt_sb);
            if (vec[i].exp_valid != 0) check($sformatf("v%0d latency", i), lat, EXP_LAT);
        end

        // Abandoned frame: start + 4 data bits, then kbclk idles high
        v0 = n_valid; e0 = n_err;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        repeat (TMO - 150) @(negedge clk);
        check("timeout early", n_err - e0, 0);
        repeat (100) @(negedge clk);
        check("timeout err", n_err - e0, 1);
        check("timeout no valid", n_valid - v0, 0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 11);
        check("after timeout valid", n_valid - v0, 1);
        check("after timeout code", {21'h0, code, is_break, is_ext, 1'b0}, {21'h0, 8'h1C, 3'b000});
        check("after timeout history", {16'h0, history}, 32'h6B1C);

        // clear landing on the same cycle as a history write
        v0 = n_valid;
        send_frame(8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 11);
        check("clear+write valid", n_valid - v0, 1);
        check("clear+write code", {24'h0, code}, 32'h33);
        check("clear+write history", {12'h0, history, hist_count}, 32'h0);
        check("clear+write sb history", {12'h0, history_sb, hist_count_sb}, 32'h0);
        send_frame(8'h21, 1'b0, 1'b0, 1'b0, 1'b0, 11);
        check("post clear history", {12'h0, history, hist_count}, {12'h0, 16'h0021, 4'd1});
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        check("plain clear", {12'h0, history, hist_count}, 32'h0);
        check("clear keeps code", {24'h0, code}, 32'h21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
